// File: rtl/rr_mux_arbiter_4_if.sv
// Valid/ready bundle between four requesters, the round-robin mux arbiter and one consumer.
// master = requester/consumer side (testbench or fabric), slave = arbiter side.
interface rr_mux_arbiter_4_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_ready;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter driving a registered 4:1 mux, one beat per cycle, source-tagged output.
// Optional ARB_BURST_EN keeps the grant on one requester for up to BURST_LEN consecutive beats.
module rr_mux_arbiter_4 #(
    parameter int WIDTH     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_mux_arbiter_4_if.slave    bus
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_src;
    logic [1:0]       r_ptr;

    logic             w_accept;
    logic             w_gnt_vld;
    logic [1:0]       w_gnt_idx;
    logic [WIDTH-1:0] w_sel_data;

    assign w_accept = !r_valid || bus.out_ready;

`ifdef ARB_BURST_EN
    logic [3:0] r_cnt;
    logic       w_hold;

    // Current owner keeps the grant while it still requests and has burst budget left.
    assign w_hold = (r_cnt != 4'd0) && (r_cnt < 4'(BURST_LEN)) && bus.in_valid[r_ptr];
`endif

    // Descending scan so the nearest requester after r_ptr is the one left standing.
    always_comb begin
        logic [1:0] w_idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_ptr + 2'(k);
            if (bus.in_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
`ifdef ARB_BURST_EN
        if (w_hold) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = r_ptr;
        end
`endif
    end

    always_comb begin
        case (w_gnt_idx)
            2'd0:    w_sel_data = bus.in_data0;
            2'd1:    w_sel_data = bus.in_data1;
            2'd2:    w_sel_data = bus.in_data2;
            default: w_sel_data = bus.in_data3;
        endcase
    end

    assign bus.in_ready  = (w_accept && w_gnt_vld && !rst) ? (4'b0001 << w_gnt_idx) : 4'b0000;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_src   = r_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= 2'd0;
            r_ptr   <= 2'd3;
        end else if (w_accept) begin
            if (w_gnt_vld) begin
                r_valid <= 1'b1;
                r_data  <= w_sel_data;
                r_src   <= w_gnt_idx;
                r_ptr   <= w_gnt_idx;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef ARB_BURST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            if (!w_gnt_vld)
                r_cnt <= 4'd0;
            else if (w_hold)
                r_cnt <= r_cnt + 4'd1;
            else
                r_cnt <= 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Self-checking bench for rr_mux_arbiter_4: vector table, directed corner sequences, random traffic vs model.
module tb_rr_mux_arbiter_4;
    localparam int W = 4;
`ifdef ARB_BURST_EN
    localparam int BL = 2;
`else
    localparam int BL = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux_arbiter_4_if #(.WIDTH(W)) bus ();

    rr_mux_arbiter_4 #(.WIDTH(W), .BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the word held at the output plus who was served last and how many times in a row.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_last;
    int           m_run;
    logic [W-1:0] d [4];

    typedef struct {
        logic [3:0] v;
        logic       ordy;
        int         src;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_last  = 3;
        m_run   = 0;
    endtask

    // Who should be granted now, or -1 for nobody.
    function automatic int model_winner(input logic [3:0] v, input logic ordy);
        if (m_valid && !ordy) return -1;
`ifdef ARB_BURST_EN
        if (m_run > 0 && m_run < BL && v[m_last]) return m_last;
`endif
        for (int k = 1; k <= 4; k++) begin
            if (v[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    task automatic drive(input logic [3:0] v, input logic ordy);
        bus.in_valid  = v;
        bus.in_data0  = d[0];
        bus.in_data1  = d[1];
        bus.in_data2  = d[2];
        bus.in_data3  = d[3];
        bus.out_ready = ordy;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(input string tag);
        int   w;
        logic acc;
        #1;
        w   = model_winner(bus.in_valid, bus.out_ready);
        acc = !m_valid || bus.out_ready;
        check($sformatf("%s.in_ready", tag), 32'(bus.in_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        @(posedge clk);
        #1;
        if (w >= 0) begin
            m_run   = (w == m_last && m_run > 0 && m_run < BL) ? m_run + 1 : 1;
            m_valid = 1'b1;
            m_data  = d[w];
            m_src   = w;
            m_last  = w;
        end else if (acc) begin
            m_valid = 1'b0;
            m_run   = 0;
        end
        check($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'(m_valid));
        check($sformatf("%s.out_data", tag),  32'(bus.out_data),  32'(m_data));
        check($sformatf("%s.out_src", tag),   32'(bus.out_src),   32'(m_src));
        @(negedge clk);
    endtask

    initial begin
        d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;
`ifdef ARB_BURST_EN
        tbl[0] = '{4'b1111, 1'b1, 0}; tbl[1] = '{4'b1111, 1'b1, 0};
        tbl[2] = '{4'b1111, 1'b1, 1}; tbl[3] = '{4'b1111, 1'b1, 1};
        tbl[4] = '{4'b1111, 1'b1, 2}; tbl[5] = '{4'b1111, 1'b1, 2};
        tbl[6] = '{4'b1111, 1'b1, 3}; tbl[7] = '{4'b1111, 1'b1, 3};
`else
        tbl[0] = '{4'b1111, 1'b1, 0}; tbl[1] = '{4'b1111, 1'b1, 1};
        tbl[2] = '{4'b1111, 1'b1, 2}; tbl[3] = '{4'b1111, 1'b1, 3};
        tbl[4] = '{4'b1111, 1'b1, 0}; tbl[5] = '{4'b1111, 1'b1, 1};
        tbl[6] = '{4'b1111, 1'b1, 2}; tbl[7] = '{4'b1111, 1'b1, 3};
`endif

        rst = 1'b1;
        model_reset();
        drive(4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_data",  32'(bus.out_data),  32'd0);
        check("rst.out_src",   32'(bus.out_src),   32'd0);
        bus.in_valid = 4'b1111;
        #1;
        check("rst.in_ready_gated", 32'(bus.in_ready), 32'd0);
        drive(4'b0000, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) cycle("idle");

        // Full contention rotation.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].ordy);
            cycle("rot");
            check("rot.src_table",  32'(bus.out_src),  32'(tbl[i].src));
            check("rot.data_table", 32'(bus.out_data), 32'(4'hA + 4'(tbl[i].src)));
        end

        // Lone requester 2, then wrap from it.
        d[2] = 4'h5;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b1);
            cycle("solo2");
            check("solo2.src", 32'(bus.out_src), 32'd2);
            check("solo2.data", 32'(bus.out_data), 32'h5);
        end
`ifndef ARB_BURST_EN
        drive(4'b1111, 1'b1);
        cycle("wrap");
        check("wrap.first_src", 32'(bus.out_src), 32'd3);
        cycle("wrap");
        check("wrap.second_src", 32'(bus.out_src), 32'd0);
`endif

        // Output stall with everyone requesting.
        d[1] = 4'h7;
        drive(4'b0010, 1'b1);
        cycle("load7");
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, 1'b0);
            cycle("stall");
            check("stall.data_hold", 32'(bus.out_data), 32'h7);
            check("stall.src_hold",  32'(bus.out_src),  32'd1);
        end
        drive(4'b1111, 1'b1);
`ifndef ARB_BURST_EN
        #1;
        check("unstall.in_ready", 32'(bus.in_ready), 32'b0100);
`endif
        cycle("unstall");

        // Asynchronous reset mid-cycle while holding a word.
        drive(4'b0100, 1'b0);
        check("prerst.out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check("arst.in_ready",  32'(bus.in_ready),  32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1111, 1'b1);
        cycle("postrst");
        check("postrst.first_src", 32'(bus.out_src), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 4; j++) d[j] = 4'($urandom);
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
